// File: rtl/i2c_config_sequencer.sv
// I2C register-write sequencer: walks a table of 16-bit words and writes each
// one to a fixed 7-bit device as a 3-byte transaction, retrying NACKed words.
module i2c_config_sequencer #(
    parameter int         NUM_REGS   = 11,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         CLK_DIV    = 125,
    parameter int         MAX_RETRY  = 3,
    parameter bit         AUTO_START = 1'b1,
    parameter int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] cfg_index,
    input  logic [15:0]      cfg_word,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       nack_count,
    output logic             i2c_clk,
    inout  wire              i2c_data
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BITS,
        STOP,
        GAP,
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       q;
    logic [26:0]      shreg;
    logic [4:0]       bit_cnt;
    logic [3:0]       bit_in_byte;
    logic [RTY_W-1:0] retry_cnt;
    logic             nack_seen;
    logic             sda_low;
    logic             auto_pend;
    logic             qtick;
    logic             in_phase;

    assign qtick    = (div_cnt == DIV_LAST);
    assign in_phase = (state == START) || (state == BITS) ||
                      (state == STOP)  || (state == GAP);

    // Open-drain SDA: only ever pull low or release.
    assign i2c_data = sda_low ? 1'b0 : 1'bz;

    // Bus outputs are registered and updated on the edge that starts each
    // quarter, so SCL/SDA never glitch and stay aligned with the quarter count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            q           <= 2'd0;
            shreg       <= '0;
            bit_cnt     <= 5'd0;
            bit_in_byte <= 4'd0;
            retry_cnt   <= '0;
            nack_seen   <= 1'b0;
            sda_low     <= 1'b0;
            i2c_clk     <= 1'b1;
            auto_pend   <= AUTO_START;
            cfg_index   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            nack_count  <= 8'd0;
        end else begin
            if (in_phase) begin
                div_cnt <= qtick ? '0 : div_cnt + 1'b1;
                if (qtick) begin
                    q <= q + 2'd1;
                end
            end else begin
                div_cnt <= '0;
                q       <= 2'd0;
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (start || auto_pend) begin
                        auto_pend  <= 1'b0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        nack_count <= 8'd0;
                        retry_cnt  <= '0;
                        cfg_index  <= '0;
                        busy       <= 1'b1;
                        i2c_clk    <= 1'b1;
                        sda_low    <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    // cfg_index is already valid here, so the table word is captured now;
                    // ACK slots hold 1 so SDA is released during them.
                    if (q == 2'd0 && div_cnt == '0) begin
                        shreg     <= {DEV_ADDR, 1'b0, 1'b1, cfg_word[15:8], 1'b1,
                                      cfg_word[7:0], 1'b1};
                        nack_seen <= 1'b0;
                    end
                    if (qtick) begin
                        unique case (q)
                            2'd0: sda_low <= 1'b1;
                            2'd1: ;
                            2'd2: i2c_clk <= 1'b0;
                            2'd3: begin
                                state       <= BITS;
                                bit_cnt     <= 5'd0;
                                bit_in_byte <= 4'd0;
                                sda_low     <= ~shreg[26];
                            end
                        endcase
                    end
                end

                BITS: begin
                    if (qtick && q == 2'd2 && bit_in_byte == 4'd8) begin
                        nack_seen <= i2c_data;
                    end
                    if (qtick) begin
                        unique case (q)
                            2'd0: ;
                            2'd1: i2c_clk <= 1'b1;
                            2'd2: ;
                            2'd3: begin
                                if (bit_in_byte == 4'd8 && nack_seen) begin
                                    if (nack_count != 8'hFF) begin
                                        nack_count <= nack_count + 8'd1;
                                    end
                                    retry_cnt <= retry_cnt + 1'b1;
                                    state     <= STOP;
                                    i2c_clk   <= 1'b0;
                                    sda_low   <= 1'b1;
                                end else if (bit_cnt == 5'd26) begin
                                    state   <= STOP;
                                    i2c_clk <= 1'b0;
                                    sda_low <= 1'b1;
                                end else begin
                                    bit_cnt     <= bit_cnt + 5'd1;
                                    bit_in_byte <= (bit_in_byte == 4'd8) ? 4'd0
                                                                         : bit_in_byte + 4'd1;
                                    shreg       <= {shreg[25:0], 1'b0};
                                    i2c_clk     <= 1'b0;
                                    sda_low     <= ~shreg[25];
                                end
                            end
                        endcase
                    end
                end

                STOP: begin
                    if (qtick) begin
                        unique case (q)
                            2'd0: i2c_clk <= 1'b1;
                            2'd1: sda_low <= 1'b0;
                            2'd2: ;
                            2'd3: state <= GAP;
                        endcase
                    end
                end

                GAP: begin
                    // nack_seen still reflects the last ACK slot of this attempt.
                    if (qtick && q == 2'd3) begin
                        if (nack_seen) begin
                            if (retry_cnt > RETRY_MAX) begin
                                state <= ERR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= START;
                            end
                        end else if (cfg_index == IDX_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cfg_index <= cfg_index + 1'b1;
                            retry_cnt <= '0;
                            state     <= START;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench for i2c_config_sequencer with a behavioural I2C slave
// that can be told to NACK specific bytes.
module tb_i2c_config_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int NUM_REGS  = 3;
    localparam int MAX_RETRY = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_index;
    logic [15:0] cfg_word;
    logic        busy, done, error;
    logic [7:0]  nack_count;
    logic        scl;
    wire         sda;
    logic        slave_low;

    logic        reset_a;
    logic [1:0]  cfg_index_a;
    logic        busy_a, done_a, error_a, scl_a;
    logic [7:0]  nack_count_a;
    wire         sda_a;

    logic [15:0] tbl [NUM_REGS];

    int checks = 0;
    int errors = 0;

    pullup (sda);
    pullup (sda_a);
    assign sda      = slave_low ? 1'b0 : 1'bz;
    assign cfg_word = tbl[cfg_index];

    i2c_config_sequencer #(
        .NUM_REGS(NUM_REGS), .DEV_ADDR(7'h1A), .CLK_DIV(CLK_DIV),
        .MAX_RETRY(MAX_RETRY), .AUTO_START(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_index(cfg_index),
        .cfg_word(cfg_word), .busy(busy), .done(done), .error(error),
        .nack_count(nack_count), .i2c_clk(scl), .i2c_data(sda)
    );

    // Second instance only exercises the automatic start after reset.
    i2c_config_sequencer #(
        .NUM_REGS(NUM_REGS), .DEV_ADDR(7'h1A), .CLK_DIV(CLK_DIV),
        .MAX_RETRY(MAX_RETRY), .AUTO_START(1'b1)
    ) dut_auto (
        .clk(clk), .reset(reset_a), .start(1'b0), .cfg_index(cfg_index_a),
        .cfg_word(16'h0000), .busy(busy_a), .done(done_a), .error(error_a),
        .nack_count(nack_count_a), .i2c_clk(scl_a), .i2c_data(sda_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: nack_mode 1 NACKs the third byte of word 1 once,
    // nack_mode 2 always NACKs the address byte of word 2.
    int         nack_mode;
    logic       slave_clear;
    logic [7:0] byte_log [$];
    logic       prev_scl, prev_sda, active, in_ack, nack_now;
    logic [7:0] rx;
    int         bit_cnt, byte_idx, good_cnt, nack_budget;

    always @(negedge clk) begin
        if (slave_clear) begin
            byte_log.delete();
            good_cnt    = 0;
            active      = 1'b0;
            in_ack      = 1'b0;
            nack_now    = 1'b0;
            bit_cnt     = 0;
            byte_idx    = 0;
            nack_budget = 1;
            slave_low   = 1'b0;
            prev_scl    = 1'b1;
            prev_sda    = 1'b1;
        end else begin
            if (prev_scl && scl && prev_sda && !sda) begin
                active   = 1'b1;
                bit_cnt  = 0;
                byte_idx = 0;
                in_ack   = 1'b0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                active    = 1'b0;
                in_ack    = 1'b0;
                slave_low = 1'b0;
            end else if (active) begin
                if (!prev_scl && scl && bit_cnt < 8) begin
                    rx      = {rx[6:0], sda};
                    bit_cnt = bit_cnt + 1;
                    if (bit_cnt == 8) begin
                        byte_log.push_back(rx);
                        nack_now = 1'b0;
                        if (nack_mode == 1 && good_cnt == 1 && byte_idx == 2 && nack_budget > 0) begin
                            nack_now    = 1'b1;
                            nack_budget = nack_budget - 1;
                        end
                        if (nack_mode == 2 && good_cnt == 2 && byte_idx == 0) nack_now = 1'b1;
                        if (!nack_now && byte_idx == 2) good_cnt = good_cnt + 1;
                    end
                end else if (prev_scl && !scl) begin
                    if (bit_cnt == 8 && !in_ack) begin
                        in_ack    = 1'b1;
                        slave_low = !nack_now;
                    end else if (in_ack) begin
                        in_ack    = 1'b0;
                        slave_low = 1'b0;
                        bit_cnt   = 0;
                        byte_idx  = byte_idx + 1;
                    end
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    typedef struct {
        logic [15:0] w0, w1, w2;
        int          mode;
        logic        exp_done;
        logic        exp_error;
        logic [7:0]  exp_nack;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_bytes [$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] w0, w1, w2, input int mode);
        tbl[0] = w0;
        tbl[1] = w1;
        tbl[2] = w2;
        nack_mode   = mode;
        slave_clear = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 slave_clear = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic build_expected(input int mode);
        exp_bytes.delete();
        for (int w = 0; w < NUM_REGS; w++) begin
            if (mode == 2 && w == 2) begin
                for (int a = 0; a < MAX_RETRY + 1; a++) exp_bytes.push_back(8'h34);
            end else begin
                for (int a = 0; a < ((mode == 1 && w == 1) ? 2 : 1); a++) begin
                    exp_bytes.push_back(8'h34);
                    exp_bytes.push_back(tbl[w][15:8]);
                    exp_bytes.push_back(tbl[w][7:0]);
                end
            end
        end
    endtask

    task automatic check_bytes(input string name);
        check_output({name, "_byte_count"}, byte_log.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++)
            check_output($sformatf("%s_byte%0d", name, i), byte_log[i], exp_bytes[i]);
    endtask

    task automatic wait_finish();
        int n;
        n = 0;
        while (n < 6000 && !(done || error)) begin
            @(posedge clk);
            #1 n++;
        end
        check_output("finish_within_budget", {31'b0, done | error}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        reset_a     = 1'b1;
        start       = 1'b0;
        nack_mode   = 0;
        slave_clear = 1'b1;
        tbl[0] = 16'h1E00;
        tbl[1] = 16'h0C00;
        tbl[2] = 16'h1201;

        vecs[0] = '{16'h1E00, 16'h0C00, 16'h1201, 0, 1'b1, 1'b0, 8'd0, 2'd2};
        vecs[1] = '{16'h1E00, 16'h0C00, 16'h1201, 1, 1'b1, 1'b0, 8'd1, 2'd2};
        vecs[2] = '{16'h1E00, 16'h0C00, 16'h1201, 2, 1'b0, 1'b1, 8'd3, 2'd2};
        vecs[3] = '{16'hA55A, 16'h00FF, 16'h8001, 0, 1'b1, 1'b0, 8'd0, 2'd2};

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_error", error, 1'b0);
        check_output("rst_nack", nack_count, 8'd0);
        check_output("rst_index", cfg_index, 2'd0);
        check_output("rst_scl", scl, 1'b1);
        check_output("rst_sda", sda, 1'b1);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_output("idle_busy", busy, 1'b0);
        check_output("idle_scl", scl, 1'b1);
        check_output("idle_sda", sda, 1'b1);

        $display("[TB] full sequence timing with ignored mid-sequence start");
        slave_clear = 1'b0;
        nack_mode   = 0;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 1440; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)    check_output("busy_after_accept", busy, 1'b1);
            if (n == 700)  start = 1'b1;
            if (n == 701)  start = 1'b0;
            if (n == 1439) check_output("done_not_early", done, 1'b0);
            if (n == 1440) check_output("done_at_1440", done, 1'b1);
        end
        check_output("timing_nack", nack_count, 8'd0);
        check_output("timing_busy", busy, 1'b0);
        check_output("timing_index", cfg_index, 2'd2);
        build_expected(0);
        check_bytes("timing");

        $display("[TB] restart after done");
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_output("restart_done", done, 1'b0);
        check_output("restart_index", cfg_index, 2'd0);
        check_output("restart_busy", busy, 1'b1);
        wait_finish();
        check_output("restart_final_done", done, 1'b1);

        for (int v = 0; v < 4; v++) begin
            $display("[TB] vector %0d", v);
            apply_stimulus(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].mode);
            wait_finish();
            repeat (3) @(posedge clk);
            #1;
            check_output($sformatf("v%0d_done", v), done, vecs[v].exp_done);
            check_output($sformatf("v%0d_error", v), error, vecs[v].exp_error);
            check_output($sformatf("v%0d_nack", v), nack_count, vecs[v].exp_nack);
            check_output($sformatf("v%0d_index", v), cfg_index, vecs[v].exp_idx);
            check_output($sformatf("v%0d_busy", v), busy, 1'b0);
            check_output($sformatf("v%0d_scl", v), scl, 1'b1);
            check_output($sformatf("v%0d_sda", v), sda, 1'b1);
            build_expected(vecs[v].mode);
            check_bytes($sformatf("v%0d", v));
        end

        $display("[TB] reset during bit 5 of word 1");
        apply_stimulus(16'h1E00, 16'h0C00, 16'h1201, 0);
        repeat (565) @(posedge clk);
        #1;
        check_output("mid_busy", busy, 1'b1);
        check_output("mid_index", cfg_index, 2'd1);
        check_output("mid_scl_low", scl, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("async_scl", scl, 1'b1);
        check_output("async_sda", sda, 1'b1);
        check_output("async_busy", busy, 1'b0);
        check_output("async_index", cfg_index, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] automatic start after reset");
        @(posedge clk);
        #3 reset_a = 1'b0;
        check_output("auto_busy_before", busy_a, 1'b0);
        @(posedge clk);
        #1;
        check_output("auto_busy", busy_a, 1'b1);
        check_output("auto_q0_scl", scl_a, 1'b1);
        check_output("auto_q0_sda", sda_a, 1'b1);
        repeat (CLK_DIV - 2) @(posedge clk);
        #1 check_output("auto_q0_end_sda", sda_a, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_output("auto_q1_sda", sda_a, 1'b0);
        check_output("auto_q1_scl", scl_a, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
